data_sync: RTL and testbench



---
 rtl/uart_sync_pkg.sv | 9 +
 rtl/data_sync_if.sv | 25 ++
 rtl/bit_sync.sv | 32 +++
 rtl/data_sync.sv | 56 +++++
 tb/tb_data_sync.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/uart_sync_pkg.sv
// Shared constants for the UART clock-domain-crossing synchronizers.
package uart_sync_pkg;

    localparam int unsigned DEF_BUS_WIDTH   = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/data_sync_if.sv
// Bus-plus-enable crossing interface: source side drives, synchronizer side receives.
interface data_sync_if #(
    parameter int unsigned BUS_WIDTH = uart_sync_pkg::DEF_BUS_WIDTH
) ();

    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 enable_pulse;

    modport master (
        output unsync_bus,
        output bus_enable,
        input  sync_bus,
        input  enable_pulse
    );

    modport slave (
        input  unsync_bus,
        input  bus_enable,
        output sync_bus,
        output enable_pulse
    );

endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer chain for level signals entering the CLK domain.
module bit_sync
    import uart_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned WIDTH      = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] sync_reg [NUM_STAGES];

    // Only stage 0 samples the foreign-domain signal.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= async_in;
            for (int i = 1; i < int'(NUM_STAGES); i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_out = sync_reg[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Destination-domain bus synchronizer: syncs the enable, captures the bus on its
// rising edge and emits a one-cycle strobe alongside the updated data.
module data_sync
    import uart_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int unsigned NUM_STAGES = DEF_SYNC_STAGES
) (
    input  logic        CLK,
    input  logic        RST,
    data_sync_if.slave  bus
);

    generate
        if (NUM_STAGES < MIN_SYNC_STAGES || NUM_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
            $error("data_sync: NUM_STAGES must be within 2..4");
        end
    endgenerate

    logic                 en_s;
    logic                 prev_en;
    logic                 pulse_comb;
    logic [BUS_WIDTH-1:0] sync_bus_q;
    logic                 enable_pulse_q;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES),
        .WIDTH      (1)
    ) u_en_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (bus.bus_enable),
        .sync_out (en_s)
    );

    assign pulse_comb = en_s & ~prev_en;

    // Bus is sampled only on the capture edge, when it is known to be stable.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_en        <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
        end else begin
            prev_en        <= en_s;
            enable_pulse_q <= pulse_comb;
            if (pulse_comb) begin
                sync_bus_q <= bus.unsync_bus;
            end
        end
    end

    assign bus.sync_bus     = sync_bus_q;
    assign bus.enable_pulse = enable_pulse_q;

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: two configurations (2 stages/8 bits, 4 stages/16 bits)
// compared each cycle against a sample-history model plus directed literal checks.
module tb_data_sync;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        en  = 1'b0;
    logic [7:0]  d8  = 8'h00;
    logic [15:0] d16 = 16'h0000;

    int checks   = 0;
    int failures = 0;
    int cnt8     = 0;
    int cnt16    = 0;

    always #5 CLK = ~CLK;

    data_sync_if #(.BUS_WIDTH(8))  if8 ();
    data_sync_if #(.BUS_WIDTH(16)) if16 ();

    assign if8.bus_enable  = en;
    assign if8.unsync_bus  = d8;
    assign if16.bus_enable = en;
    assign if16.unsync_bus = d16;

    data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (if8.slave)
    );

    data_sync #(.BUS_WIDTH(16), .NUM_STAGES(4)) dut16 (
        .CLK (CLK),
        .RST (RST),
        .bus (if16.slave)
    );

    // Model: enable samples taken at each edge since reset (newest at back).
    // A pulse appears N edges after the first edge that sampled enable high
    // following one that sampled it low; the bus is taken at that same edge.
    bit          hist[$];
    logic [7:0]  exp8   = 8'h00;
    logic        exp_p8 = 1'b0;
    logic [15:0] exp16  = 16'h0000;
    logic        exp_p16 = 1'b0;

    function automatic bit ago(input int d);
        int idx;
        idx = hist.size() - 1 - d;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hist.delete();
            exp8    <= 8'h00;
            exp_p8  <= 1'b0;
            exp16   <= 16'h0000;
            exp_p16 <= 1'b0;
        end else begin
            hist.push_back(en);
            if (hist.size() > 8) void'(hist.pop_front());
            exp_p8  <= ago(2) && !ago(3);
            exp_p16 <= ago(4) && !ago(5);
            if (ago(2) && !ago(3)) exp8  <= d8;
            if (ago(4) && !ago(5)) exp16 <= d16;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("sync_bus8",      32'(if8.sync_bus),      32'(exp8));
        check("enable_pulse8",  32'(if8.enable_pulse),  32'(exp_p8));
        check("sync_bus16",     32'(if16.sync_bus),     32'(exp16));
        check("enable_pulse16", 32'(if16.enable_pulse), 32'(exp_p16));
        cnt8  += int'(if8.enable_pulse);
        cnt16 += int'(if16.enable_pulse);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with enable high and an all-ones bus
        RST = 1'b0; en = 1'b1; d8 = 8'hFF; d16 = 16'hFFFF;
        cyc(4);
        check("rst_sync_bus8",  32'(if8.sync_bus),      32'h0);
        check("rst_pulse8",     32'(if8.enable_pulse),  32'h0);
        check("rst_sync_bus16", 32'(if16.sync_bus),     32'h0);
        en = 1'b0;
        cyc(1);
        RST = 1'b1;
        cyc(6);

        // Basic capture: pulse at edge 3 (2 stages) and edge 5 (4 stages)
        d8 = 8'hA5; d16 = 16'hBEEF; en = 1'b1;
        after_edge(); check("e1_pulse8", 32'(if8.enable_pulse), 32'h0);
        after_edge(); check("e2_pulse8", 32'(if8.enable_pulse), 32'h0);
        after_edge();
        check("e3_pulse8",  32'(if8.enable_pulse),  32'h1);
        check("e3_bus8",    32'(if8.sync_bus),      32'hA5);
        check("e3_pulse16", 32'(if16.enable_pulse), 32'h0);
        after_edge(); check("e4_pulse8", 32'(if8.enable_pulse), 32'h0);
        after_edge();
        check("e5_pulse16", 32'(if16.enable_pulse), 32'h1);
        check("e5_bus16",   32'(if16.sync_bus),     32'hBEEF);
        after_edge(); check("e6_pulse16", 32'(if16.enable_pulse), 32'h0);
        @(negedge CLK);
        cyc(4);

        // Hold and fall: data change while high and the falling edge are ignored
        d8 = 8'h3C; d16 = 16'h1234;
        cyc(3);
        en = 1'b0;
        cyc(8);
        check("hold_bus8",  32'(if8.sync_bus),  32'hA5);
        check("hold_bus16", 32'(if16.sync_bus), 32'hBEEF);
        check("hold_cnt8",  32'(cnt8),          32'd1);
        check("hold_cnt16", 32'(cnt16),         32'd1);

        // Two transfers separated by a 4-cycle gap
        d8 = 8'h11; d16 = 16'h1111; en = 1'b1;
        cyc(6);
        en = 1'b0;
        cyc(4);
        check("xfer1_bus8", 32'(if8.sync_bus), 32'h11);
        d8 = 8'h22; d16 = 16'h2222; en = 1'b1;
        cyc(6);
        en = 1'b0;
        cyc(8);
        check("xfer2_bus8",  32'(if8.sync_bus),  32'h22);
        check("xfer2_bus16", 32'(if16.sync_bus), 32'h2222);
        check("xfer_cnt8",   32'(cnt8),          32'd3);
        check("xfer_cnt16",  32'(cnt16),         32'd3);

        // Mid-operation reset discards the pending edge
        d8 = 8'h5A; d16 = 16'h5A5A; en = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(3);
        check("midrst_bus8",  32'(if8.sync_bus),  32'h0);
        check("midrst_bus16", 32'(if16.sync_bus), 32'h0);
        check("midrst_cnt8",  32'(cnt8),          32'd3);
        RST = 1'b1;
        after_edge(); check("rel_e1_pulse8", 32'(if8.enable_pulse), 32'h0);
        after_edge(); check("rel_e2_pulse8", 32'(if8.enable_pulse), 32'h0);
        after_edge();
        check("rel_e3_pulse8", 32'(if8.enable_pulse), 32'h1);
        check("rel_e3_bus8",   32'(if8.sync_bus),     32'h5A);
        @(negedge CLK);
        en = 1'b0;
        cyc(8);
        check("rel_cnt8",  32'(cnt8),  32'd4);
        check("rel_cnt16", 32'(cnt16), 32'd4);

        // Random levels, glitches, data churn and occasional resets
        for (int i = 0; i < 600; i++) begin
            int hold;
            en   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 8));
            for (int j = 0; j < hold; j++) begin
                d8  = 8'($urandom);
                d16 = 16'($urandom);
                RST = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                cyc(1);
            end
        end
        RST = 1'b1;
        en  = 1'b0;
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
